// File: rtl/delta_conv_pe.sv
// rtl/delta_conv_pe.sv - delta-weight convolution processing element
//
// One job takes an activation x at (ih, iw), a base weight w0, run-length
// coded signed weight deltas and a list of {channel, kh, kw} index entries.
// The running product p starts at x*w0 and is advanced by x*delta between
// runs. Each index entry becomes one partial-sum write to
// (channel, ih-kh, iw-kw). Entries that land outside the output map are
// retired in one cycle without a write.
//
// Ports
//   clock_i, reset_i           clock (rising edge), asynchronous active-high reset
//   start_i / busy_o / done_o  job request (sampled in IDLE), job active, completion pulse
//   input_val_i                activation x (signed)
//   input_height_index_i       activation row ih
//   input_width_index_i        activation column iw
//   weight_val_i               base weight w0 (signed)
//   base_sim_i                 number of entries that use w0
//   delta_vals_i               packed signed deltas, entry i at [i*DELTA_LEN +: DELTA_LEN]
//   delta_sims_i               packed run lengths, same packing
//   index_vals_i               packed {channel, kh, kw}, entry 0 in the LSBs
//   w_valid_o / w_ready_i      write handshake towards the output-buffer accumulator
//   w_channel_index_o          destination channel
//   w_height_index_o           destination row (ih-kh)
//   w_width_index_o            destination column (iw-kw)
//   w_val_o                    partial sum p (signed, wraps modulo 2^OUT_BIN_LEN)
//
// Build option
//   DELTA_PE_ZERO_SKIP_EN  when defined, entries are retired without a write
//                          while p == 0, at one entry per cycle.
//
// KERNEL_HEIGHT, KERNEL_WIDTH and OUTPUT_CHANNEL are expected to be powers of
// two of at least 2 so that every index field has a non-zero width.

module delta_conv_pe #(
    parameter int BIN_LEN        = 8,
    parameter int OUT_BIN_LEN    = 24,
    parameter int DELTA_LEN      = 4,
    parameter int DELTA_SIM_LEN  = 4,
    parameter int DELTA_NUM      = 7,
    parameter int INDEX_NUM      = 32,
    parameter int OUTPUT_CHANNEL = 4,
    parameter int KERNEL_HEIGHT  = 2,
    parameter int KERNEL_WIDTH   = 2,
    parameter int INPUT_HEIGHT   = 16,
    parameter int INPUT_WIDTH    = 16,
    localparam int CH_W  = $clog2(OUTPUT_CHANNEL),
    localparam int KH_W  = $clog2(KERNEL_HEIGHT),
    localparam int KW_W  = $clog2(KERNEL_WIDTH),
    localparam int IH_W  = $clog2(INPUT_HEIGHT),
    localparam int IW_W  = $clog2(INPUT_WIDTH),
    localparam int IDX_W = CH_W + KH_W + KW_W
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    output logic                               busy_o,
    input  logic [BIN_LEN-1:0]                 input_val_i,
    input  logic [IH_W-1:0]                    input_height_index_i,
    input  logic [IW_W-1:0]                    input_width_index_i,
    input  logic [BIN_LEN-1:0]                 weight_val_i,
    input  logic [DELTA_SIM_LEN-1:0]           base_sim_i,
    input  logic [DELTA_NUM*DELTA_LEN-1:0]     delta_vals_i,
    input  logic [DELTA_NUM*DELTA_SIM_LEN-1:0] delta_sims_i,
    input  logic [INDEX_NUM*IDX_W-1:0]         index_vals_i,
    output logic                               w_valid_o,
    input  logic                               w_ready_i,
    output logic [CH_W-1:0]                    w_channel_index_o,
    output logic [IH_W-1:0]                    w_height_index_o,
    output logic [IW_W-1:0]                    w_width_index_o,
    output logic [OUT_BIN_LEN-1:0]             w_val_o,
    output logic                               done_o
);

    localparam int E_W  = $clog2(INDEX_NUM + 1);
    localparam int EP_W = $clog2(INDEX_NUM);
    localparam int G_W  = $clog2(DELTA_NUM + 1);
    localparam int GP_W = $clog2(DELTA_NUM);

    localparam logic [E_W-1:0]  E_END = E_W'(INDEX_NUM);
    localparam logic [G_W-1:0]  G_END = G_W'(DELTA_NUM);
    localparam logic [IH_W:0]   OUT_H = (IH_W + 1)'(INPUT_HEIGHT - KERNEL_HEIGHT + 1);
    localparam logic [IW_W:0]   OUT_W = (IW_W + 1)'(INPUT_WIDTH - KERNEL_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EMIT   = 2'd1,
        S_UPDATE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [BIN_LEN-1:0]                 x_q, x_d;
    logic [IH_W-1:0]                    ih_q, ih_d;
    logic [IW_W-1:0]                    iw_q, iw_d;
    logic [DELTA_NUM*DELTA_LEN-1:0]     dv_q, dv_d;
    logic [DELTA_NUM*DELTA_SIM_LEN-1:0] ds_q, ds_d;
    logic [INDEX_NUM*IDX_W-1:0]         idx_q, idx_d;
    logic [OUT_BIN_LEN-1:0]             p_q, p_d;
    logic [DELTA_SIM_LEN-1:0]           run_q, run_d;
    logic [E_W-1:0]                     e_q, e_d;
    logic [G_W-1:0]                     g_q, g_d;

    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               w_valid_q, w_valid_d;
    logic [CH_W-1:0]                    w_ch_q, w_ch_d;
    logic [IH_W-1:0]                    w_oh_q, w_oh_d;
    logic [IW_W-1:0]                    w_ow_q, w_ow_d;
    logic [OUT_BIN_LEN-1:0]             w_val_q, w_val_d;

    logic [DELTA_LEN-1:0]               delta_arr [DELTA_NUM];
    logic [DELTA_SIM_LEN-1:0]           sim_arr   [DELTA_NUM];
    logic [IDX_W-1:0]                   idx_arr   [INDEX_NUM];
    logic [GP_W-1:0]                    g_sel;
    logic [EP_W-1:0]                    e_sel;
    logic [IDX_W-1:0]                   ent;
    logic [CH_W-1:0]                    ent_ch;
    logic [KH_W-1:0]                    ent_kh;
    logic [KW_W-1:0]                    ent_kw;
    logic [IH_W:0]                      oh_ext;
    logic [IW_W:0]                      ow_ext;
    logic                               in_range;
    logic                               emit_ok;

    function automatic logic [OUT_BIN_LEN-1:0] sext_bin(input logic [BIN_LEN-1:0] v);
        return {{(OUT_BIN_LEN - BIN_LEN){v[BIN_LEN-1]}}, v};
    endfunction

    function automatic logic [OUT_BIN_LEN-1:0] sext_delta(input logic [DELTA_LEN-1:0] v);
        return {{(OUT_BIN_LEN - DELTA_LEN){v[DELTA_LEN-1]}}, v};
    endfunction

    // Delta groups come from the latched job; g can sit one past the last
    // group once every run is used up, so the selector is clamped.
    always_comb begin
        for (int i = 0; i < DELTA_NUM; i++) begin
            delta_arr[i] = dv_q[i*DELTA_LEN +: DELTA_LEN];
            sim_arr[i]   = ds_q[i*DELTA_SIM_LEN +: DELTA_SIM_LEN];
        end
        g_sel = (g_q < G_END) ? g_q[GP_W-1:0] : '0;
    end

    // Sequencing: entries, run counts and delta groups.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        ih_d    = ih_q;
        iw_d    = iw_q;
        dv_d    = dv_q;
        ds_d    = ds_q;
        idx_d   = idx_q;
        p_d     = p_q;
        run_d   = run_q;
        e_d     = e_q;
        g_d     = g_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    x_d   = input_val_i;
                    ih_d  = input_height_index_i;
                    iw_d  = input_width_index_i;
                    dv_d  = delta_vals_i;
                    ds_d  = delta_sims_i;
                    idx_d = index_vals_i;
                    p_d   = sext_bin(input_val_i) * sext_bin(weight_val_i);
                    run_d = base_sim_i;
                    e_d   = '0;
                    g_d   = '0;
                    state_d = (base_sim_i == '0) ? S_UPDATE : S_EMIT;
                end
            end
            S_EMIT: begin
                // An entry without w_valid (dropped or skipped) retires
                // unconditionally; a real write retires on the handshake.
                if (!w_valid_q || w_ready_i) begin
                    e_d   = e_q + E_W'(1);
                    run_d = run_q - DELTA_SIM_LEN'(1);
                    if (e_d == E_END) begin
                        state_d = S_DONE;
                    end else if (run_d == '0) begin
                        state_d = (g_q == G_END) ? S_DONE : S_UPDATE;
                    end
                end
            end
            S_UPDATE: begin
                p_d   = p_q + sext_bin(x_q) * sext_delta(delta_arr[g_sel]);
                run_d = sim_arr[g_sel];
                g_d   = g_q + G_W'(1);
                if (run_d != '0) begin
                    state_d = S_EMIT;
                end else if (g_d == G_END) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are derived from the next-state
    // values: the entry that will be current after this edge decides
    // w_valid and the payload.
    always_comb begin
        for (int i = 0; i < INDEX_NUM; i++) begin
            idx_arr[i] = idx_d[i*IDX_W +: IDX_W];
        end
        e_sel  = (e_d < E_END) ? e_d[EP_W-1:0] : '0;
        ent    = idx_arr[e_sel];
        ent_ch = ent[IDX_W-1 -: CH_W];
        ent_kh = ent[KH_W+KW_W-1 -: KH_W];
        ent_kw = ent[KW_W-1:0];

        // One extra bit holds the sign of ih-kh / iw-kw.
        oh_ext = {1'b0, ih_d} - (IH_W + 1)'(ent_kh);
        ow_ext = {1'b0, iw_d} - (IW_W + 1)'(ent_kw);
        in_range = !oh_ext[IH_W] && (oh_ext < OUT_H) &&
                   !ow_ext[IW_W] && (ow_ext < OUT_W);

        emit_ok = (state_d == S_EMIT) && in_range;
`ifdef DELTA_PE_ZERO_SKIP_EN
        emit_ok = emit_ok && (p_d != '0);
`endif

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        w_valid_d = emit_ok;

        // Payload is only reloaded for a real write; while stalled e_d
        // equals e_q, so the reload reproduces the same values.
        w_ch_d  = w_ch_q;
        w_oh_d  = w_oh_q;
        w_ow_d  = w_ow_q;
        w_val_d = w_val_q;
        if (emit_ok) begin
            w_ch_d  = ent_ch;
            w_oh_d  = oh_ext[IH_W-1:0];
            w_ow_d  = ow_ext[IW_W-1:0];
            w_val_d = p_d;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            ih_q      <= '0;
            iw_q      <= '0;
            dv_q      <= '0;
            ds_q      <= '0;
            idx_q     <= '0;
            p_q       <= '0;
            run_q     <= '0;
            e_q       <= '0;
            g_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_valid_q <= 1'b0;
            w_ch_q    <= '0;
            w_oh_q    <= '0;
            w_ow_q    <= '0;
            w_val_q   <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            ih_q      <= ih_d;
            iw_q      <= iw_d;
            dv_q      <= dv_d;
            ds_q      <= ds_d;
            idx_q     <= idx_d;
            p_q       <= p_d;
            run_q     <= run_d;
            e_q       <= e_d;
            g_q       <= g_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            w_valid_q <= w_valid_d;
            w_ch_q    <= w_ch_d;
            w_oh_q    <= w_oh_d;
            w_ow_q    <= w_ow_d;
            w_val_q   <= w_val_d;
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign w_valid_o         = w_valid_q;
    assign w_channel_index_o = w_ch_q;
    assign w_height_index_o  = w_oh_q;
    assign w_width_index_o   = w_ow_q;
    assign w_val_o           = w_val_q;

endmodule

// File: doc/delta_conv_pe.md
# delta_conv_pe

Parametrised delta-weight convolution processing element: the next generation of the single-activation PE. It accepts one input activation with a base weight, a list of signed weight deltas with run lengths, and an index list. It incrementally forms the products x·w (p += x·δ, no full multiply after the first) and streams one partial-sum write per index entry to the output-buffer accumulator. Over the previous PE it adds generic channel/kernel/width parameters, a valid/ready write port with backpressure, and out-of-range output dropping at feature-map borders.

## Interface
- BIN_LEN, 8: activation and weight width, signed two's complement
- OUT_BIN_LEN, 24: product width
- DELTA_LEN, 4: signed delta width
- DELTA_SIM_LEN, 4: run-length width
- DELTA_NUM, 7: delta entries per job
- INDEX_NUM, 32: index entries per job (≥ OUTPUT_CHANNEL·KERNEL_HEIGHT·KERNEL_WIDTH)
- OUTPUT_CHANNEL, 4 / KERNEL_HEIGHT, 2 / KERNEL_WIDTH, 2: powers of two; log2 widths are derived
- INPUT_HEIGHT, 16 / INPUT_WIDTH, 16: output map is (INPUT_HEIGHT−KERNEL_HEIGHT+1)×(INPUT_WIDTH−KERNEL_WIDTH+1), stride 1

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  job request, sampled only in IDLE
- busy  out  1  job in progress
- input_val  in  BIN_LEN  activation x
- input_height_index / input_width_index  in  log2 INPUT dims  activation position (ih, iw)
- weight_val  in  BIN_LEN  base weight w0
- base_sim  in  DELTA_SIM_LEN  entries using w0
- delta_vals  in  DELTA_NUM·DELTA_LEN  packed deltas, entry i at bits [i·DELTA_LEN +: DELTA_LEN]
- delta_sims  in  DELTA_NUM·DELTA_SIM_LEN  packed run lengths
- index_vals  in  INDEX_NUM·IDX_W  packed {channel, kh, kw}, entry 0 in the LSBs
- w_valid  out  1  write request
- w_ready  in  1  accumulator accepts the write
- w_channel_index / w_height_index / w_width_index  out  log2 widths  destination
- w_val  out  OUT_BIN_LEN  signed product
- done  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, EMIT, UPDATE, DONE.
- IDLE with start=1: latch all job inputs, set p = sext(x)·sext(w0) and group g=0 with run count base_sim, set entry pointer e=0, go to EMIT. If base_sim=0, go to UPDATE instead.
- EMIT, one index entry per handshake:
  - out_h = ih − kh, out_w = iw − kw.
  - If either is negative or ≥ the output dimension, drop the entry: it takes one cycle with no w_valid.
  - Otherwise hold w_valid with a stable payload {channel, out_h, out_w, p} until w_ready.
  - After each consumed entry, e++ and decrement the run count.
- Run exhausted with groups remaining: go to UPDATE. There p += sext(x)·sext(δ_g), the run count loads delta_sims[g], and g++. A zero run loops UPDATE again. Otherwise return to EMIT.
- Termination: when e reaches INDEX_NUM or all DELTA_NUM groups are exhausted, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic: p wraps modulo 2^OUT_BIN_LEN, with no saturation.
- start while busy is ignored.

## Timing
- Reset values of all outputs: 0. Reset clears the state to IDLE; w_valid falls asynchronously, mid-job included, and the partial job is discarded.
- busy=1 from the cycle after start acceptance through the DONE cycle.
- First w_valid appears one cycle after start when base_sim>0 and entry 0 is in range.
- Throughput: one entry per cycle with w_ready held high. Each UPDATE costs one cycle.
- w_valid & w_ready in the same cycle as the last entry: DONE is asserted in the next cycle.
- Payload changes only after a handshake. w_valid never drops without w_ready.

## Configuration
- DELTA_PE_ZERO_SKIP_EN defined: when p==0, entries are consumed at one per cycle with no w_valid, the same as dropped entries.
- DELTA_PE_ZERO_SKIP_EN undefined: zero products are written normally.

## Test plan
- Base run: x=3, (ih,iw)=(1,1), w0=2, base_sim=15, all runs 0, 16 entries c0..3×kh×kw -> first 15 entries each write w_val=6 with out=(1−kh, 1−kw), then done. Entry 15 is never consumed.
- Delta groups: x=3, w0=2, base_sim=4, δ0=+1 run 4, δ1=−3 run 8 -> writes 6×4, 9×4, 0×8 without zero-skip. With DELTA_PE_ZERO_SKIP_EN, only 8 writes, and done arrives at the same cycle count.
- Border: (ih,iw)=(0,0), 16 valid entries -> only the 4 kh=kw=0 entries write. The 12 others are dropped, one cycle each.
- Backpressure: hold w_ready=0 for 5 cycles during the 3rd write -> w_valid and payload stay stable, the write count is exact, and there are no duplicates.
- Signed: x=−4, w0=7, δ0=−8 run 1 -> w_val −28, then +4 (wrap-free at 24 bits).
- Reset asserted mid-EMIT -> w_valid, busy, and done are 0 immediately. A new start after release runs a clean job with correct values.
